// File: rtl/sobel_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen_if
// Purpose  : Pixel stream in / 3x3 window out bundle for sobel_window_gen.
// Revision : 1.0  initial release
// ============================================================================
interface sobel_window_gen_if #(
  parameter int NBIT = 8
);
  logic            pix_valid;
  logic [NBIT-1:0] pix_in;
  logic            sof;
  logic [NBIT-1:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic            win_valid;
  logic            frame_done;

  modport master (
    output pix_valid, pix_in, sof,
    input  P0, P1, P2, P3, P4, P5, P6, P7, P8, win_valid, frame_done
  );

  modport slave (
    input  pix_valid, pix_in, sof,
    output P0, P1, P2, P3, P4, P5, P6, P7, P8, win_valid, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Purpose  : Raster pixel stream to registered 3x3 neighbourhood with strobes.
// Revision : 1.0  initial release
// ============================================================================
module sobel_window_gen #(
  parameter int NBIT  = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sobel_window_gen_if.slave  if_bus
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] c_X_TWO  = XW'(2);
  localparam logic [YW-1:0] c_Y_TWO  = YW'(2);
  localparam logic [XW-1:0] c_X_ONE  = XW'(1);
  localparam logic [YW-1:0] c_Y_ONE  = YW'(1);

  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [XW-1:0]   w_x;
  logic [YW-1:0]   w_y;
  logic            w_acc;
  logic            w_win_ok;
  logic            w_last_x;
  logic            w_last_y;

  logic [NBIT-1:0] r_lb0 [IMG_W];
  logic [NBIT-1:0] r_lb1 [IMG_W];
  logic [NBIT-1:0] w_lb0_rd;
  logic [NBIT-1:0] w_lb1_rd;

  logic [NBIT-1:0] r_sh     [9];
  logic [NBIT-1:0] w_sh_nxt [9];
  logic [NBIT-1:0] r_p      [9];
  logic            r_win_valid;
  logic            r_frame_done;

  // sof forces the current pixel to (0,0) regardless of counter state
  assign w_acc    = if_bus.pix_valid;
  assign w_x      = if_bus.sof ? '0 : r_x;
  assign w_y      = if_bus.sof ? '0 : r_y;
  assign w_last_x = (w_x == c_X_LAST);
  assign w_last_y = (w_y == c_Y_LAST);
  assign w_win_ok = (w_x >= c_X_TWO) && (w_y >= c_Y_TWO);

  assign w_lb0_rd = r_lb0[w_x];
  assign w_lb1_rd = r_lb1[w_x];

  always_comb begin
    w_sh_nxt[0] = r_sh[1];
    w_sh_nxt[1] = r_sh[2];
    w_sh_nxt[2] = w_lb0_rd;
    w_sh_nxt[3] = r_sh[4];
    w_sh_nxt[4] = r_sh[5];
    w_sh_nxt[5] = w_lb1_rd;
    w_sh_nxt[6] = r_sh[7];
    w_sh_nxt[7] = r_sh[8];
    w_sh_nxt[8] = if_bus.pix_in;
  end

  // Line buffers carry no reset; border gating hides stale rows
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[w_x] <= w_lb1_rd;
      r_lb1[w_x] <= if_bus.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_sh[i] <= '0;
        r_p[i]  <= '0;
      end
    end else begin
      r_win_valid  <= w_acc && w_win_ok;
      r_frame_done <= w_acc && w_last_x && w_last_y;
      if (w_acc) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : (w_y + c_Y_ONE);
        end else begin
          r_x <= w_x + c_X_ONE;
          r_y <= w_y;
        end
        for (int i = 0; i < 9; i++) begin
          r_sh[i] <= w_sh_nxt[i];
        end
        // Outputs only move on a complete window and hold otherwise
        if (w_win_ok) begin
          for (int i = 0; i < 9; i++) begin
            r_p[i] <= w_sh_nxt[i];
          end
        end
      end
    end
  end

  assign if_bus.P0         = r_p[0];
  assign if_bus.P1         = r_p[1];
  assign if_bus.P2         = r_p[2];
  assign if_bus.P3         = r_p[3];
  assign if_bus.P4         = r_p[4];
  assign if_bus.P5         = r_p[5];
  assign if_bus.P6         = r_p[6];
  assign if_bus.P7         = r_p[7];
  assign if_bus.P8         = r_p[8];
  assign if_bus.win_valid  = r_win_valid;
  assign if_bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_gen
// Purpose  : Self-checking bench for sobel_window_gen on a 4x4 frame.
// Revision : 1.0  initial release
// ============================================================================
module tb_sobel_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.NBIT(8)) bus ();

  sobel_window_gen #(.NBIT(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the frame as an image array; a window is a 3x3 crop
  logic [7:0]  img [H][W];
  int          mx = 0, my = 0;
  logic        ewv = 1'b0, efd = 1'b0;
  logic [71:0] ewin = '0;

  logic [71:0] wq [$];
  logic [71:0] s1 [$];
  int          fd_cnt = 0, fd_win = 0, consec = 0;
  logic        prev_wv = 1'b0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] dut_win();
    return {bus.P0, bus.P1, bus.P2, bus.P3, bus.P4, bus.P5, bus.P6, bus.P7, bus.P8};
  endfunction

  initial begin
    int cx, cy;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mx = 0; my = 0; ewv = 1'b0; efd = 1'b0; ewin = '0;
      end else begin
        ewv = 1'b0;
        efd = 1'b0;
        if (bus.pix_valid) begin
          cx = bus.sof ? 0 : mx;
          cy = bus.sof ? 0 : my;
          img[cy][cx] = bus.pix_in;
          if (cx >= 2 && cy >= 2) begin
            ewv  = 1'b1;
            ewin = {img[cy-2][cx-2], img[cy-2][cx-1], img[cy-2][cx],
                    img[cy-1][cx-2], img[cy-1][cx-1], img[cy-1][cx],
                    img[cy][cx-2],   img[cy][cx-1],   img[cy][cx]};
          end
          efd = (cx == W-1) && (cy == H-1);
          mx  = (cx == W-1) ? 0 : cx + 1;
          my  = (cx == W-1) ? ((cy == H-1) ? 0 : cy + 1) : cy;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("win_valid", 72'(bus.win_valid), 72'(ewv));
      chk("frame_done", 72'(bus.frame_done), 72'(efd));
      chk("window", dut_win(), ewin);
      if (bus.win_valid === 1'b1) wq.push_back(dut_win());
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.frame_done === 1'b1 && bus.win_valid === 1'b1) fd_win++;
      if (bus.win_valid === 1'b1 && prev_wv) consec++;
      prev_wv = (bus.win_valid === 1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pix(input logic [7:0] v, input logic s, input int gap);
    bus.pix_valid = 1'b1;
    bus.pix_in    = v;
    bus.sof       = s;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.sof       = 1'b0;
    idle(gap);
  endtask

  task automatic send_frame(input logic [7:0] base, input logic s, input int gap, input int npix);
    for (int i = 0; i < npix; i++)
      send_pix(base + 8'(16 * (i / W) + (i % W)), s && (i == 0), gap);
  endtask

  task automatic clear_log();
    wq.delete();
    fd_cnt = 0; fd_win = 0; consec = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    bus.sof       = 1'b0;
    idle(3);
    chk("rst_win", dut_win(), 72'h0);
    chk("rst_flags", 72'({bus.win_valid, bus.frame_done}), 72'h0);
    rst_n = 1'b1;

    // idle after release
    idle(10);
    chk("idle_win", dut_win(), 72'h0);
    chk("idle_flags", 72'({bus.win_valid, bus.frame_done}), 72'h0);

    // continuous frame
    clear_log();
    send_frame(8'h00, 1'b1, 0, W*H);
    idle(2);
    chk("s1_count", 72'(wq.size()), 72'd4);
    if (wq.size() == 4) begin
      chk("s1_first", wq[0], 72'h00_01_02_10_11_12_20_21_22);
      chk("s1_last",  wq[3], 72'h11_12_13_21_22_23_31_32_33);
    end
    chk("s1_fd", 72'(fd_cnt), 72'd1);
    chk("s1_fd_with_win", 72'(fd_win), 72'd1);
    s1 = wq;

    // gapped frame
    clear_log();
    send_frame(8'h00, 1'b1, 3, W*H);
    idle(2);
    chk("s2_count", 72'(wq.size()), 72'd4);
    if (wq.size() == 4 && s1.size() == 4)
      for (int i = 0; i < 4; i++) chk("s2_seq", wq[i], s1[i]);
    chk("s2_consec", 72'(consec), 72'd0);
    chk("s2_fd", 72'(fd_cnt), 72'd1);

    // back-to-back frames, second without sof
    clear_log();
    send_frame(8'h00, 1'b1, 0, W*H);
    send_frame(8'h80, 1'b0, 0, W*H);
    idle(2);
    chk("s3_count", 72'(wq.size()), 72'd8);
    if (wq.size() == 8) begin
      chk("s3_f2_first", wq[4], 72'h80_81_82_90_91_92_A0_A1_A2);
      chk("s3_f2_last",  wq[7], 72'h91_92_93_A1_A2_A3_B1_B2_B3);
    end
    chk("s3_fd", 72'(fd_cnt), 72'd2);

    // sof at index 7 abandons the frame
    clear_log();
    send_frame(8'h00, 1'b1, 0, 7);
    send_frame(8'h40, 1'b1, 0, W*H);
    idle(2);
    chk("s4_count", 72'(wq.size()), 72'd4);
    if (wq.size() == 4)
      chk("s4_first", wq[0], 72'h40_41_42_50_51_52_60_61_62);
    chk("s4_fd", 72'(fd_cnt), 72'd1);

    // asynchronous reset mid-frame
    clear_log();
    send_frame(8'h00, 1'b1, 0, 13);
    chk("s5_pre_nonzero", 72'(dut_win() != 72'h0), 72'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_win", dut_win(), 72'h0);
    chk("s5_rst_flags", 72'({bus.win_valid, bus.frame_done}), 72'h0);
    idle(2);
    chk("s5_rst_hold", dut_win(), 72'h0);
    rst_n = 1'b1;
    clear_log();
    send_frame(8'h00, 1'b0, 0, W*H);
    idle(2);
    chk("s5_count", 72'(wq.size()), 72'd4);
    if (wq.size() == 4 && s1.size() == 4)
      for (int i = 0; i < 4; i++) chk("s5_seq", wq[i], s1[i]);
    chk("s5_fd", 72'(fd_cnt), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
